key_matrix_scanner: RTL

Parametrised keypad matrix scanner for the HY-207 button block. It drives row lines one-hot active-low, synchronises and debounces every key, and emits per-key down/up pulse vectors. It also emits a single-entry encoded key-event register with a valid/ready handshake and a sticky overrun flag. It sits between the board row/column pins (rows on 51-53, columns on 54-57 by default) and the counter-management and LED logic.

---
 rtl/key_scan_pkg.sv | 13 +
 rtl/key_matrix_scanner_debounce.sv | 46 ++++
 rtl/key_matrix_scanner.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/key_scan_pkg.sv
// Shared constants and helpers for the keypad matrix scanner.
package key_scan_pkg;

  localparam int   DB_CNT_W = 4;
  localparam logic EV_DOWN  = 1'b0;
  localparam logic EV_UP    = 1'b1;

  // Width of a key index; never narrower than one bit.
  function automatic int code_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_matrix_scanner_debounce.sv
// Per-key integrating debouncer: a change is accepted after DEBOUNCE_SCANS
// consecutive differing samples; the toggle pulse aligns with the new state.
module key_debounce
  import key_scan_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_en,
  input  logic sample_bit,
  output logic state,
  output logic toggle
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_SCANS - 1);

  logic [DB_CNT_W-1:0] cnt_reg;
  logic                state_reg;
  logic                toggle_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      state_reg  <= 1'b0;
      toggle_reg <= 1'b0;
    end else begin
      toggle_reg <= 1'b0;
      if (sample_en) begin
        if (sample_bit == state_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_reg  <= ~state_reg;
          toggle_reg <= 1'b1;
          cnt_reg    <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign state  = state_reg;
  assign toggle = toggle_reg;

endmodule

// File: rtl/key_matrix_scanner.sv
// Keypad matrix scanner: row rotator, column synchroniser, per-key debounce and
// a single-entry event register. Define KEY_SCAN_AUTOREPEAT_EN for auto-repeat.
module key_matrix_scanner
  import key_scan_pkg::*;
#(
  parameter  int ROWS           = 3,
  parameter  int COLS           = 4,
  parameter  int SCAN_DIV       = 50000,
  parameter  int DEBOUNCE_SCANS = 4,
  parameter  int REPEAT_DELAY   = 25,
  parameter  int REPEAT_RATE    = 5,
  localparam int KEYS           = ROWS * COLS,
  localparam int CODE_W         = code_width(KEYS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [COLS-1:0]   i_cols,
  output logic [ROWS-1:0]   o_rows,
  output logic [KEYS-1:0]   o_key_state,
  output logic [KEYS-1:0]   o_flag_btn_down,
  output logic [KEYS-1:0]   o_flag_btn_up,
  output logic [CODE_W-1:0] o_code,
  output logic              o_code_up,
  output logic              o_code_valid,
  input  logic              i_code_ready,
  output logic              o_overrun
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("key_matrix_scanner: parameter out of range");
  end

  logic [1:0]        rst_sync_reg;
  logic              rst_int_n;
  logic [COLS-1:0]   col_meta_reg, col_sync_reg;
  logic [DIV_W-1:0]  dwell_reg;
  logic [ROW_W-1:0]  row_idx_reg, row_idx_next;
  logic [ROWS-1:0]   rows_reg;
  logic              scan_tick;
  logic [KEYS-1:0]   key_state, key_toggle;
  logic [CODE_W-1:0] tog_code, ev_code, code_reg;
  logic              tog_up, any_toggle, tog_multi;
  logic              ev_req, ev_up, ev_multi, pop, capture;
  logic              code_up_reg, code_valid_reg, overrun_reg;

  // Reset asserts immediately but releases two clocks later, synchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_reg <= 2'b00;
    else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_int_n = rst_sync_reg[1];

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      col_meta_reg <= '1;
      col_sync_reg <= '1;
    end else begin
      col_meta_reg <= i_cols;
      col_sync_reg <= col_meta_reg;
    end
  end

  assign scan_tick    = (dwell_reg == DIV_W'(SCAN_DIV - 1));
  assign row_idx_next = (row_idx_reg == ROW_W'(ROWS - 1)) ? '0 : row_idx_reg + 1'b1;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      dwell_reg   <= '0;
      row_idx_reg <= '0;
      rows_reg    <= ~ROWS'(1);
    end else if (scan_tick) begin
      dwell_reg   <= '0;
      row_idx_reg <= row_idx_next;
      rows_reg    <= ~(ROWS'(1) << row_idx_next);
    end else begin
      dwell_reg <= dwell_reg + 1'b1;
    end
  end

  for (genvar gi = 0; gi < KEYS; gi++) begin : g_key
    key_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
      .clk        (clk),
      .rst_n      (rst_int_n),
      .sample_en  (scan_tick && (row_idx_reg == ROW_W'(gi / COLS))),
      .sample_bit (~col_sync_reg[gi % COLS]),
      .state      (key_state[gi]),
      .toggle     (key_toggle[gi])
    );
  end

  // Lowest-index toggling key wins the event register.
  always_comb begin
    tog_code = '0;
    tog_up   = EV_DOWN;
    for (int k = KEYS - 1; k >= 0; k--) begin
      if (key_toggle[k]) begin
        tog_code = CODE_W'(k);
        tog_up   = ~key_state[k];
      end
    end
  end

  assign any_toggle = |key_toggle;
  assign tog_multi  = |(key_toggle & (key_toggle - KEYS'(1)));

`ifdef KEY_SCAN_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0]  rep_cnt_reg, rep_target;
  logic              rep_first_reg, single_held, frame_tick, rep_fire;
  logic [CODE_W-1:0] held_code;

  assign frame_tick  = scan_tick && (row_idx_reg == ROW_W'(ROWS - 1));
  assign single_held = (key_state != '0) && ((key_state & (key_state - KEYS'(1))) == '0);
  assign rep_target  = rep_first_reg ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_RATE - 1);
  assign rep_fire    = single_held && !any_toggle && frame_tick && (rep_cnt_reg == rep_target);

  always_comb begin
    held_code = '0;
    for (int k = KEYS - 1; k >= 0; k--) begin
      if (key_state[k]) held_code = CODE_W'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rep_cnt_reg   <= '0;
      rep_first_reg <= 1'b1;
    end else if (any_toggle || !single_held) begin
      rep_cnt_reg   <= '0;
      rep_first_reg <= 1'b1;
    end else if (frame_tick) begin
      if (rep_cnt_reg == rep_target) begin
        rep_cnt_reg   <= '0;
        rep_first_reg <= 1'b0;
      end else begin
        rep_cnt_reg <= rep_cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    ev_req   = any_toggle;
    ev_code  = tog_code;
    ev_up    = tog_up;
    ev_multi = tog_multi;
    if (rep_fire) begin
      ev_req   = 1'b1;
      ev_code  = held_code;
      ev_up    = EV_DOWN;
      ev_multi = 1'b0;
    end
  end
`else
  assign ev_req   = any_toggle;
  assign ev_code  = tog_code;
  assign ev_up    = tog_up;
  assign ev_multi = tog_multi;
`endif

  assign pop     = code_valid_reg && i_code_ready;
  assign capture = ev_req && (!code_valid_reg || pop);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      code_reg       <= '0;
      code_up_reg    <= 1'b0;
      code_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      if (capture) begin
        code_reg       <= ev_code;
        code_up_reg    <= ev_up;
        code_valid_reg <= 1'b1;
      end else if (pop) begin
        code_valid_reg <= 1'b0;
      end
      if (ev_multi || (ev_req && !capture)) overrun_reg <= 1'b1;
    end
  end

  assign o_rows          = rows_reg;
  assign o_key_state     = key_state;
  assign o_flag_btn_down = key_toggle & key_state;
  assign o_flag_btn_up   = key_toggle & ~key_state;
  assign o_code          = code_reg;
  assign o_code_up       = code_up_reg;
  assign o_code_valid    = code_valid_reg;
  assign o_overrun       = overrun_reg;

endmodule
